shift_hold_sreg: RTL
====================

# shift_hold_sreg

Parametrised serial shift register with a programmable shift/hold duty cycle. It shifts a serial bit stream for a run-time burst of `shift_len` cycles, then freezes for `hold_len` cycles, and repeats. Shift direction is selectable, and the register supports parallel load. It generalises the fixed 4-bit, 2-shift/2-hold buffer stage in the serial datapath, and drives serial-to-parallel staging and bit-paced links.

## Interface
Parameters:
- `WIDTH`, 8: register length in bits (≥2).
- `CNTW`, 4: width of the burst-length inputs and the internal phase counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low; all state is cleared while `rst`=0.
- `en`  in  1  run enable; 0 forces IDLE.
- `dir`  in  1  shift direction: 0 = left (din→q[0]), 1 = right (din→q[WIDTH-1]).
- `din`  in  1  serial input.
- `load`  in  1  parallel load strobe.
- `pdin`  in  WIDTH  parallel load data.
- `shift_len`  in  CNTW  shift cycles per burst; sampled at burst start.
- `hold_len`  in  CNTW  hold cycles after each burst; sampled at burst start; 0 means no hold phase.
- `q`  out  WIDTH  register contents.
- `dout`  out  1  registered serial output: the bit shifted out on the last shift.
- `state`  out  2  current phase: 0 IDLE, 1 SHIFT, 2 HOLD.
- `burst_done`  out  1  one-cycle pulse, high in the cycle after the last shift of a burst.

## Operation
- Reset (`rst`=0) values: `q`=0, `dout`=0, `state`=IDLE, `burst_done`=0, counter=0, latched lengths=0.
- **IDLE**
  - Holds `q` and `dout`.
  - Moves to SHIFT on an edge where `en`=1 and `shift_len`≠0.
  - On that edge, latches `shift_len` into `sl` and `hold_len` into `hl`, and sets the counter to 0.
  - The entry edge performs no shift.
- **SHIFT**
  - Every edge performs one shift.
  - Left shift: `dout`←q[WIDTH-1], then q←{q[WIDTH-2:0],din}.
  - Right shift: `dout`←q[0], then q←{din,q[WIDTH-1:1]}.
  - The counter increments on each shift.
  - On the shift where counter = `sl`-1, `burst_done` is set for the next cycle and the counter goes to 0.
  - After that last shift, the next state is HOLD if `hl`≠0.
  - If `hl`=0, a new burst starts immediately: `sl` and `hl` are re-latched and the state stays SHIFT.
- **HOLD**
  - `q` and `dout` are frozen; the counter increments each edge.
  - At counter = `hl`-1 the next state is SHIFT, the counter goes to 0, and `sl`/`hl` are re-latched.
  - If the newly sampled `shift_len`=0 at that point, the next state is IDLE instead.
- **en**
  - `en`=0 sampled in SHIFT or HOLD causes IDLE on that edge, with no shift that cycle and the counter cleared.
  - `q` and `dout` are retained.
- **load**
  - `load` has priority over shift/hold in every state.
  - On a load: q←`pdin`, `dout` unchanged, counter←0.
  - If `en`=1 and `shift_len`≠0, the state goes to SHIFT with lengths re-latched; otherwise it goes to IDLE.
- `dir` is sampled every shift edge; changing it mid-burst takes effect on the next shift.
- The counter is a CNTW-bit register. Comparisons against `sl`-1 and `hl`-1 are CNTW-bit, and the counter never wraps, because lengths are at most 2^CNTW-1.

## Timing
- Latency from `en` rising to the first shift: 1 edge (IDLE→SHIFT edge, then first shift on the next edge).
- The serial path is 1 cycle from `din` to q[0]/q[WIDTH-1]. The bit shifted out appears on `dout` on the same edge that it leaves `q`.
- Steady-state period is `sl`+`hl` cycles, with exactly `sl` shifts per period.
- `burst_done` is high for exactly 1 cycle per burst, aligned with the first HOLD cycle (or the first cycle of the next burst when `hl`=0).
- Asserting `rst` mid-burst clears all state immediately. After release, the first edge with `en`=1 behaves as entry from IDLE.
- Input changes to `shift_len`/`hold_len` mid-burst have no effect until the next burst start.

## Test plan
- **Default cycle:** WIDTH=4, sl=2, hl=2, `dir`=0, `din` pattern 1,0,1,1,… → `q` changes only on shift edges, going 0001, 0010, hold, hold, 0101, 1011. `burst_done` pulses every 4 cycles.
- **Right shift with parallel load:** WIDTH=8, load `pdin`=8'hA5, `dir`=1, `din`=0, sl=8, hl=0 → `dout` sequence 1,0,1,0,0,1,0,1 and `q`=0 after 8 shifts. `burst_done` goes high once at the end of the 8 shifts, then the next burst begins.
- **Zero lengths:** with `shift_len`=0 and `en`=1, the state stays IDLE. With hl=0 and sl=3, shifting is continuous and `burst_done` pulses every 3rd cycle.
- **Mid-operation interrupts:**
  - Drop `en` on shift 2 of sl=5 → no further shifts and `state`=0. Re-enable → full 5-shift burst.
  - Assert `load` during HOLD → `q`=`pdin` and SHIFT restarts the next edge.
- **Async reset:** pulse `rst` low between clock edges mid-burst → `q`, `dout`, `state` and `burst_done` go to 0 immediately, without waiting for a clock edge.
- **Length re-latch:** change `shift_len` from 2 to 3 during a burst → the current burst completes 2 shifts and the next burst does 3.

Source files
------------

// File: rtl/shift_hold_sreg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : shift_hold_sreg                                               |
// | Function : Serial shift register that repeats a burst of shift_len       |
// |            shifts followed by hold_len frozen cycles, with parallel load |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+

module shift_hold_sreg #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             din,
    input  logic             load,
    input  logic [WIDTH-1:0] pdin,
    input  logic [CNTW-1:0]  shift_len,
    input  logic [CNTW-1:0]  hold_len,
    output logic [WIDTH-1:0] q,
    output logic             dout,
    output logic [1:0]       state,
    output logic             burst_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [CNTW-1:0]  sl_q, sl_d;
    logic [CNTW-1:0]  hl_q, hl_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             dout_q, dout_d;
    logic             done_q, done_d;

    logic             w_start;
    logic             w_shift_last;
    logic             w_hold_last;
    logic [WIDTH-1:0] w_shifted;
    logic             w_out_bit;

    assign w_start      = en && (shift_len != '0);
    assign w_shift_last = (cnt_q == (sl_q - CNTW'(1)));
    assign w_hold_last  = (cnt_q == (hl_q - CNTW'(1)));
    assign w_shifted    = dir ? {din, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], din};
    assign w_out_bit    = dir ? sreg_q[0] : sreg_q[WIDTH-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sl_d    = sl_q;
        hl_d    = hl_q;
        sreg_d  = sreg_q;
        dout_d  = dout_q;
        done_d  = 1'b0;

        if (load) begin
            sreg_d = pdin;
            cnt_d  = '0;
            if (w_start) begin
                state_d = S_SHIFT;
                sl_d    = shift_len;
                hl_d    = hold_len;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_start) begin
                        state_d = S_SHIFT;
                        sl_d    = shift_len;
                        hl_d    = hold_len;
                        cnt_d   = '0;
                    end
                end

                S_SHIFT: begin
                    if (!en) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        sreg_d = w_shifted;
                        dout_d = w_out_bit;
                        if (w_shift_last) begin
                            done_d = 1'b1;
                            cnt_d  = '0;
                            if (hl_q != '0) begin
                                state_d = S_HOLD;
                            end else begin
                                // Back-to-back bursts: re-latch now; a zero length parks in IDLE
                                sl_d    = shift_len;
                                hl_d    = hold_len;
                                state_d = (shift_len != '0) ? S_SHIFT : S_IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q + CNTW'(1);
                        end
                    end
                end

                S_HOLD: begin
                    if (!en) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (w_hold_last) begin
                        cnt_d   = '0;
                        sl_d    = shift_len;
                        hl_d    = hold_len;
                        state_d = (shift_len != '0) ? S_SHIFT : S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sl_q    <= '0;
            hl_q    <= '0;
            sreg_q  <= '0;
            dout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sl_q    <= sl_d;
            hl_q    <= hl_d;
            sreg_q  <= sreg_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    assign q          = sreg_q;
    assign dout       = dout_q;
    assign state      = state_q;
    assign burst_done = done_q;

endmodule

`default_nettype wire
